// File: rtl/bram_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_uart_tx_if
//  Description : Control, BRAM read port and UART status bundle for bram_uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_uart_tx_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       word_count;
    logic [ADDR_W-1:0] addr_io;
    logic              ena;
    logic [15:0]       data_in_io;
    logic              tx;
    logic              busy;
    logic              done;
    logic              led_tx;

    modport master (
        output start, base_addr, word_count, data_in_io,
        input  addr_io, ena, tx, busy, done, led_tx
    );

    modport slave (
        input  start, base_addr, word_count, data_in_io,
        output addr_io, ena, tx, busy, done, led_tx
    );
endinterface
`default_nettype wire

// File: rtl/bram_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bram_uart_tx
//  Description : Dumps a run of 16-bit BRAM words over an 8N1 UART, high byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 16
) (
    input  logic          clk_100,
    input  logic          rst,
    bram_uart_tx_if.slave bus
);
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_ADDR   = 4'd1,
        S_RD_WAIT   = 4'd2,
        S_LOAD      = 4'd3,
        S_START_BIT = 4'd4,
        S_DATA_BITS = 4'd5,
        S_STOP_BIT  = 4'd6,
        S_NEXT      = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_remain;
    logic [15:0]         r_word;
    logic                r_low_sel;
    logic [2:0]          r_bit_idx;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic                r_tx;
    logic                w_bit_done;
    logic                w_in_frame;
    logic                w_tx_next;
    logic [7:0]          w_cur_byte;

    assign w_in_frame = (r_state == S_START_BIT) || (r_state == S_DATA_BITS) ||
                        (r_state == S_STOP_BIT);
    assign w_bit_done = (r_baud_cnt == c_BAUD_LAST);
    assign w_cur_byte = r_low_sel ? r_word[7:0] : r_word[15:8];

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.word_count != 16'd0) ? S_RD_ADDR : S_DONE;
                end
            end
            S_RD_ADDR: w_state_next = S_RD_WAIT;
            S_RD_WAIT: w_state_next = S_LOAD;
            S_LOAD:    w_state_next = S_START_BIT;
            S_START_BIT: begin
                w_tx_next = 1'b0;
                if (w_bit_done) w_state_next = S_DATA_BITS;
            end
            S_DATA_BITS: begin
                w_tx_next = w_cur_byte[r_bit_idx];
                if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP_BIT;
            end
            S_STOP_BIT: begin
                // The low byte follows the high byte's stop bit with no idle gap.
                if (w_bit_done) w_state_next = r_low_sel ? S_NEXT : S_START_BIT;
            end
            S_NEXT:  w_state_next = (r_remain != 16'd1) ? S_RD_ADDR : S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_word     <= '0;
            r_low_sel  <= 1'b0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr   <= bus.base_addr;
                        r_remain <= bus.word_count;
                    end
                end
                S_LOAD: begin
                    r_word    <= bus.data_in_io;
                    r_low_sel <= 1'b0;
                end
                S_DATA_BITS: if (w_bit_done) r_bit_idx <= r_bit_idx + 3'd1;
                S_STOP_BIT:  if (w_bit_done) r_low_sel <= 1'b1;
                S_NEXT: begin
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_remain <= r_remain - 16'd1;
                end
                default: ;
            endcase
            if (w_in_frame && !w_bit_done) r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
            else                           r_baud_cnt <= '0;
        end
    end

    assign bus.addr_io = r_addr;
    assign bus.ena     = (r_state == S_RD_ADDR);
    assign bus.tx      = r_tx;
    assign bus.busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.led_tx  = bus.busy;
endmodule
`default_nettype wire
